// File: rtl/hlu_pkg.sv
// Shared HI/LO unit definitions: decoder control encoding, default latencies, counter FSM states.
package hlu_pkg;

    // hluControl encoding shared with the decoder
    localparam logic [3:0] HLU_NOP  = 4'b0000;
    localparam logic [3:0] HLU_MULT = 4'b0001;
    localparam logic [3:0] HLU_DIV  = 4'b0010;

    // Default busy lengths after the start edge
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    // Cycle counter width; holds both defaults without wrapping
    localparam int unsigned CNT_W = 4;

    // Counter FSM view: idle when the counter is zero, running otherwise
    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StRun  = 1'b1
    } hlu_state_e;

endpackage

// File: rtl/hilo_unit.sv
// Execute-stage multiply/divide unit owning HI/LO. Results are computed at the start edge and
// held in pending registers; a down-counter models the fixed latency before they commit.
module hilo_unit
    import hlu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  hlu_control,
    input  logic        hlu_unsigned,
    input  logic        hlu_write,
    input  logic        hlu_dst,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        flush,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    logic [CNT_W-1:0] count;
    logic [31:0]      p_hi;
    logic [31:0]      p_lo;
    logic             no_commit;

    hlu_state_e state;
    logic       start_accepted;
    logic       write_accepted;
    logic       is_div;

    logic [63:0] prod;
    logic        a_neg;
    logic        b_neg;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] divisor;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    // Request acceptance and status outputs
    always_comb begin
        state          = (count == '0) ? StIdle : StRun;
        start_accepted = (hlu_control != HLU_NOP) && !flush && (state == StIdle);
        // A start in the same decode wins over an mthi/mtlo write
        write_accepted = hlu_write && !flush && (state == StIdle) && (hlu_control == HLU_NOP);
        is_div         = (hlu_control == HLU_DIV);
        busy           = start_accepted || (state == StRun);
        rd_data        = hlu_dst ? hi : lo;
    end

    // Product and sign-magnitude divide; magnitudes avoid the 0x80000000 / -1 overflow case
    always_comb begin
        if (hlu_unsigned) begin
            prod = {32'd0, rs_data} * {32'd0, rt_data};
        end else begin
            prod = {{32{rs_data[31]}}, rs_data} * {{32{rt_data[31]}}, rt_data};
        end
        a_neg   = !hlu_unsigned && rs_data[31];
        b_neg   = !hlu_unsigned && rt_data[31];
        a_mag   = a_neg ? (~rs_data + 32'd1) : rs_data;
        b_mag   = b_neg ? (~rt_data + 32'd1) : rt_data;
        // Dummy divisor keeps the divider defined; the result is discarded via no_commit
        divisor = (rt_data == 32'd0) ? 32'd1 : b_mag;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;
        quot    = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
        // Remainder follows the dividend's sign
        rem     = a_neg ? (~r_mag + 32'd1) : r_mag;
    end

    // Counter FSM, pending result capture, commit and mthi/mtlo writes
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi        <= '0;
            lo        <= '0;
            count     <= '0;
            p_hi      <= '0;
            p_lo      <= '0;
            no_commit <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (start_accepted) begin
                        if (is_div) begin
                            count     <= CNT_W'(DIV_CYCLES);
                            p_hi      <= rem;
                            p_lo      <= quot;
                            no_commit <= (rt_data == 32'd0);
                        end else begin
                            count     <= CNT_W'(MULT_CYCLES);
                            p_hi      <= prod[63:32];
                            p_lo      <= prod[31:0];
                            no_commit <= 1'b0;
                        end
                    end else if (write_accepted) begin
                        if (hlu_dst) begin
                            hi <= rs_data;
                        end else begin
                            lo <= rs_data;
                        end
                    end
                end
                StRun: begin
                    // New starts and writes are ignored while running; flush does not abort
                    count <= count - 1'b1;
                    if (count == CNT_W'(1) && !no_commit) begin
                        hi <= p_hi;
                        lo <= p_lo;
                    end
                end
                default: count <= '0;
            endcase
        end
    end

endmodule
